// File: rtl/snf_rxchan_lcrd.sv
// snf_rxchan_lcrd: CHI-E RX link-layer channel receiver; issues L-credits, buffers flits, forwards valid/ready.
// Optional feature macro SNF_RXCHAN_BYPASS_EN: an empty FIFO is bypassed in the same cycle when the consumer is ready.
`ifndef CHIE_DAT_FLIT_WIDTH
`define CHIE_DAT_FLIT_WIDTH 392
`endif

module snf_rxchan_lcrd #(
    parameter int FLIT_W   = `CHIE_DAT_FLIT_WIDTH,
    parameter int LCRD_NUM = 4,
    parameter int OPC_LSB  = 0,
    parameter int OPC_W    = 4,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_state,
    input  logic              rxflitpend,
    input  logic              rxflitv,
    input  logic [FLIT_W-1:0] rxflit,
    output logic              rx_lcrdv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic              rx_active,
    output logic              crd_idle,
    output logic              err_crd_ovf
);

    localparam int PTR_W = (LCRD_NUM > 1) ? $clog2(LCRD_NUM) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LCRD_NUM);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LCRD_NUM - 1);

    logic [FLIT_W-1:0] mem_r [LCRD_NUM];

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  occ_r;
    logic [CNT_W-1:0]  crd_out_r;
    logic              rx_lcrdv_r;
    logic              out_valid_r;
    logic              rx_active_r;
    logic              crd_idle_r;
    logic              err_crd_ovf_r;

    logic [PTR_W-1:0]  wr_ptr_s;
    logic [PTR_W-1:0]  rd_ptr_s;
    logic [CNT_W-1:0]  occ_s;
    logic [CNT_W-1:0]  crd_out_s;
    logic [CNT_W-1:0]  space_s;
    logic              crd_avail_s;
    logic              is_lcrd_ret_s;
    logic              consume_s;
    logic              drop_s;
    logic              grant_s;
    logic              bypass_s;
    logic              enq_s;
    logic              deq_s;
    logic [FLIT_W-1:0] out_flit_s;

    // Pointers wrap at LCRD_NUM, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    // Credit decision and flit classification from the current registered state.
    always_comb begin
        space_s       = CNT_MAX - occ_r - crd_out_r;
        crd_avail_s   = (crd_out_r != CNT_ZERO);
        is_lcrd_ret_s = (rxflit[OPC_LSB +: OPC_W] == {OPC_W{1'b0}});
        consume_s     = rxflitv & crd_avail_s;
        drop_s        = rxflitv & ~crd_avail_s;
        grant_s       = run_state & (space_s != CNT_ZERO);
`ifdef SNF_RXCHAN_BYPASS_EN
        bypass_s      = consume_s & ~is_lcrd_ret_s & (occ_r == CNT_ZERO) & out_ready;
`else
        bypass_s      = 1'b0;
`endif
        enq_s         = consume_s & ~is_lcrd_ret_s & ~bypass_s;
        deq_s         = out_valid_r & out_ready;
    end

    // Next FIFO pointers/occupancy and outstanding-credit count.
    always_comb begin
        wr_ptr_s  = wr_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        occ_s     = occ_r;
        crd_out_s = crd_out_r;
        case ({enq_s, deq_s})
            2'b10: begin
                wr_ptr_s = ptr_inc(wr_ptr_r);
                occ_s    = occ_r + CNT_ONE;
            end
            2'b01: begin
                rd_ptr_s = ptr_inc(rd_ptr_r);
                occ_s    = occ_r - CNT_ONE;
            end
            2'b11: begin
                wr_ptr_s = ptr_inc(wr_ptr_r);
                rd_ptr_s = ptr_inc(rd_ptr_r);
            end
            default: begin
                occ_s = occ_r;
            end
        endcase
        // A grant and a consumed credit in the same cycle cancel out.
        case ({grant_s, consume_s})
            2'b10:   crd_out_s = crd_out_r + CNT_ONE;
            2'b01:   crd_out_s = crd_out_r - CNT_ONE;
            default: crd_out_s = crd_out_r;
        endcase
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            occ_r         <= CNT_ZERO;
            crd_out_r     <= CNT_ZERO;
            rx_lcrdv_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            rx_active_r   <= 1'b0;
            crd_idle_r    <= 1'b1;
            err_crd_ovf_r <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_s;
            rd_ptr_r      <= rd_ptr_s;
            occ_r         <= occ_s;
            crd_out_r     <= crd_out_s;
            rx_lcrdv_r    <= grant_s;
            out_valid_r   <= (occ_s != CNT_ZERO);
            rx_active_r   <= rxflitpend | (occ_s != CNT_ZERO);
            crd_idle_r    <= (crd_out_s == CNT_ZERO);
            err_crd_ovf_r <= err_crd_ovf_r | drop_s;
        end
    end

    // Flit storage; contents are don't-care until written, reads are gated by out_valid_r.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_r[wr_ptr_r] <= rxflit;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Head flit, forced to zero whenever nothing is presented.
    always_comb begin
        out_flit_s = {FLIT_W{1'b0}};
        if (bypass_s) begin
            out_flit_s = rxflit;
        end else if (out_valid_r) begin
            out_flit_s = mem_r[rd_ptr_r];
        end else begin
            out_flit_s = {FLIT_W{1'b0}};
        end
    end

    assign rx_lcrdv    = rx_lcrdv_r;
    assign out_valid   = out_valid_r | bypass_s;
    assign out_flit    = out_flit_s;
    assign rx_active   = rx_active_r;
    assign crd_idle    = crd_idle_r;
    assign err_crd_ovf = err_crd_ovf_r;

endmodule
